// File: rtl/line_fill_memory.sv
// Backing-store responder for the two-way cache: line-fill reads return two beats,
// write-through byte writes return a one-beat ack, both after a fixed access latency.
module line_fill_memory #(
    parameter int LATENCY = 4,
    parameter int MEM_AW  = 10,
    parameter int DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw_,
    input  logic [13:0]       req_line,
    input  logic              req_word,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic              rsp_word,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,
    output logic              busy
);
    localparam int LINE_W = 14;
    localparam int KEEP_W = MEM_AW - 1;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_BEAT0 = 3'd2,
        S_BEAT1 = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rw_q;
    logic [KEEP_W-1:0]   line_q;
    logic                word_q;
    logic [DATA_W-1:0]   data_q;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_word_q, rsp_word_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;
    logic                accept_s;
    logic                mem_we_s;
    logic [MEM_AW-1:0]   addr_wr_s, addr_b0_s, addr_b1_s;
    logic                unused_line_s;
    logic [DATA_W-1:0]   mem_q [2**MEM_AW];

    // Line bits above the stored byte address alias onto lower lines
    assign unused_line_s = ^req_line[LINE_W-1:KEEP_W];

    assign accept_s  = req_valid && req_ready_q;
    assign addr_wr_s = {line_q, word_q};
    assign addr_b0_s = {line_q, 1'b0};
    assign addr_b1_s = {line_q, 1'b1};
    assign mem_we_s  = (state_q == S_WAIT) && (state_d == S_WRITE);

    // State, latency counter and registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_word_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_word_q  <= rsp_word_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    // Request fields captured on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q   <= 1'b0;
            line_q <= '0;
            word_q <= 1'b0;
            data_q <= '0;
        end else if (accept_s) begin
            rw_q   <= req_rw_;
            line_q <= req_line[KEEP_W-1:0];
            word_q <= req_word;
            data_q <= req_data;
        end
    end

    // Storage array; a write commits on the edge that enters WRITE, ahead of its ack
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[addr_wr_s] <= data_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = rw_q ? S_BEAT0 : S_WRITE;
                end
            end
            S_BEAT0: state_d = S_BEAT1;
            S_BEAT1: state_d = S_IDLE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the state being entered, so the beat shows in that state's cycle
    always_comb begin
        rsp_valid_d = 1'b0;
        rsp_word_d  = 1'b0;
        rsp_data_d  = '0;
        rsp_last_d  = 1'b0;
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        case (state_d)
            S_BEAT0: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = mem_q[addr_b0_s];
            end
            S_BEAT1: begin
                rsp_valid_d = 1'b1;
                rsp_word_d  = 1'b1;
                rsp_data_d  = mem_q[addr_b1_s];
                rsp_last_d  = 1'b1;
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_word_d  = word_q;
                rsp_last_d  = 1'b1;
            end
            default: begin
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_word  = rsp_word_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_line_fill_memory.sv
// Bench for line_fill_memory: a cycle-timeline model checks the LATENCY=4 instance every
// cycle; directed literal checks pin key results; a LATENCY=1 instance covers the short build.
module tb_line_fill_memory;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        req_valid = 1'b0, req_rw_ = 1'b0, req_word = 1'b0;
    logic [13:0] req_line = 14'd0;
    logic [7:0]  req_data = 8'd0;
    logic        req_ready, rsp_valid, rsp_word, rsp_last, busy;
    logic [7:0]  rsp_data;

    logic        v1 = 1'b0, rw1 = 1'b0, w1 = 1'b0;
    logic [13:0] line1 = 14'd0;
    logic [7:0]  d1 = 8'd0;
    logic        ready1, valid1, word1, last1, busy1;
    logic [7:0]  data1;

    int tests = 0;
    int fails = 0;

    line_fill_memory #(.LATENCY(LAT), .MEM_AW(10), .DATA_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw_(req_rw_), .req_line(req_line), .req_word(req_word), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_word(rsp_word), .rsp_data(rsp_data),
        .rsp_last(rsp_last), .busy(busy)
    );

    line_fill_memory #(.LATENCY(1), .MEM_AW(10), .DATA_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
        .req_rw_(rw1), .req_line(line1), .req_word(w1), .req_data(d1),
        .rsp_valid(valid1), .rsp_word(word1), .rsp_data(data1),
        .rsp_last(last1), .busy(busy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Model: a request accepted at edge A is WAIT for LAT cycles, then beats at A+LAT (and A+LAT+1 for reads)
    logic [7:0] mmem [1024];
    bit         mknown [1024];
    bit         inflight = 1'b0;
    bit         rst_seen = 1'b0;
    int         cyc = 0;
    int         acc = 0;
    bit         m_rw, m_word;
    int         m_line;
    logic [7:0] m_data;

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(posedge clk) begin
        int k, endk, a;
        logic [4:0] e_ctl, a_ctl;
        logic [7:0] e_data;
        bit e_known;
        #2;
        cyc++;
        if (rst_seen || !rst_n) begin
            inflight = 1'b0;
            rst_seen = 1'b0;
        end
        if (rst_n) begin
            endk = m_rw ? LAT + 2 : LAT + 1;
            if (inflight && (cyc - 1 - acc) >= endk) inflight = 1'b0;
            if (!inflight && req_valid) begin
                inflight = 1'b1;
                acc      = cyc;
                m_rw     = req_rw_;
                m_line   = int'(req_line);
                m_word   = req_word;
                m_data   = req_data;
            end
            if (inflight && !m_rw && (cyc - acc) == LAT) begin
                a = (m_line * 2 + int'(m_word)) % 1024;
                mmem[a]   = m_data;
                mknown[a] = 1'b1;
            end
        end
        k      = cyc - acc;
        endk   = m_rw ? LAT + 2 : LAT + 1;
        e_ctl  = 5'b10000;
        e_data = 8'h00;
        e_known = 1'b1;
        if (inflight && k < endk) begin
            e_ctl = 5'b01000;
            if (m_rw && (k == LAT || k == LAT + 1)) begin
                a = (m_line * 2 + ((k == LAT) ? 0 : 1)) % 1024;
                e_ctl   = {2'b01, 1'b1, (k != LAT), (k != LAT)};
                e_data  = mmem[a];
                e_known = mknown[a];
            end else if (!m_rw && k == LAT) begin
                e_ctl = {2'b01, 1'b1, m_word, 1'b1};
            end
        end
        a_ctl = {req_ready, busy, rsp_valid, rsp_word, rsp_last};
        chk("model_ctl{ready,busy,valid,word,last}", 32'(a_ctl), 32'(e_ctl));
        if (e_known) chk("model_rsp_data", 32'(rsp_data), 32'(e_data));
    end

    task automatic send(input bit rw, input logic [13:0] line, input bit w,
                        input logic [7:0] d, output time t_acc);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_rw_ = rw; req_line = line; req_word = w; req_data = d;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("accept_within_bound", 32'(req_ready), 32'd1);
        @(posedge clk);
        t_acc = $time;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_within_bound", 32'(rsp_valid), 32'd1);
    endtask

    task automatic write_ack(input logic [13:0] line, input bit w, input logic [7:0] d);
        int n;
        time t;
        send(1'b0, line, w, d, t);
        wait_rsp(n);
        chk("wr_latency", 32'(n), 32'(LAT));
        chk("wr_ack_data", 32'(rsp_data), 32'h00);
        chk("wr_ack_last", 32'(rsp_last), 32'd1);
        chk("wr_ack_word", 32'(rsp_word), 32'(w));
        @(negedge clk);
        chk("wr_after_ready", 32'({req_ready, rsp_valid}), 32'b10);
    endtask

    task automatic read_tail(input logic [7:0] e0, input logic [7:0] e1);
        int n;
        wait_rsp(n);
        chk("rd_latency", 32'(n), 32'(LAT));
        chk("rd_beat0", 32'({rsp_word, rsp_last, rsp_data}), 32'({2'b00, e0}));
        @(negedge clk);
        chk("rd_beat1", 32'({rsp_valid, rsp_word, rsp_last, rsp_data}), 32'({3'b111, e1}));
        @(negedge clk);
        chk("rd_after", 32'({req_ready, busy, rsp_valid}), 32'b100);
    endtask

    task automatic read_beats(input logic [13:0] line, input logic [7:0] e0, input logic [7:0] e1);
        time t;
        send(1'b1, line, 1'b0, 8'h00, t);
        read_tail(e0, e1);
    endtask

    task automatic op1(input bit rw, input logic [13:0] line, input bit w, input logic [7:0] d,
                       input logic [7:0] e0, input logic [7:0] e1);
        @(negedge clk);
        chk("l1_ready", 32'(ready1), 32'd1);
        v1 = 1'b1; rw1 = rw; line1 = line; w1 = w; d1 = d;
        @(negedge clk);
        v1 = 1'b0;
        chk("l1_wait", 32'({valid1, busy1, ready1}), 32'b010);
        @(negedge clk);
        if (rw) begin
            chk("l1_beat0", 32'({valid1, word1, last1, data1}), 32'({3'b100, e0}));
            @(negedge clk);
            chk("l1_beat1", 32'({valid1, word1, last1, data1}), 32'({3'b111, e1}));
        end else begin
            chk("l1_ack", 32'({valid1, word1, last1, data1}), 32'({1'b1, w, 1'b1, 8'h00}));
        end
        @(negedge clk);
        chk("l1_idle", 32'({valid1, ready1, busy1}), 32'b010);
    endtask

    initial begin
        time t_a, t_b;
        int  cnt;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({req_ready, busy, rsp_valid, rsp_word, rsp_last, rsp_data}),
            32'({5'b10000, 8'h00}));
        rst_n = 1'b1;

        write_ack(14'h152, 1'b0, 8'h5C);
        write_ack(14'h152, 1'b1, 8'hE1);

        // T1: mid-cycle reset while a fill waits
        send(1'b1, 14'h152, 1'b0, 8'h00, t_a);
        chk("t1_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("t1_async_reset", 32'({req_ready, busy, rsp_valid}), 32'b100);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: fill of line 0x152
        read_beats(14'h152, 8'h5C, 8'hE1);

        // T3: write then read back
        write_ack(14'h0F7, 1'b0, 8'h91);
        write_ack(14'h0F7, 1'b1, 8'h3C);
        read_beats(14'h0F7, 8'h91, 8'h3C);

        // T4: second request held during a fill
        send(1'b1, 14'h152, 1'b0, 8'h00, t_a);
        send(1'b1, 14'h0F7, 1'b0, 8'h00, t_b);
        chk("t4_accept_gap", 32'((t_b - t_a) / 10), 32'(LAT + 3));
        read_tail(8'h91, 8'h3C);

        // T5: reset during WAIT abandons an uncommitted write
        write_ack(14'h033, 1'b0, 8'h4D);
        write_ack(14'h033, 1'b1, 8'h66);
        send(1'b0, 14'h033, 1'b0, 8'hAA, t_a);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("t5_async_reset", 32'({req_ready, busy, rsp_valid}), 32'b100);
        cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("t5_no_ack", 32'(cnt), 32'd0);
        read_beats(14'h033, 8'h4D, 8'h66);

        // T6: LATENCY=1 instance, lines 0x3FFF and 0x21FF alias onto line 0x1FF
        op1(1'b0, 14'h3FFF, 1'b1, 8'h77, 8'h00, 8'h00);
        op1(1'b0, 14'h21FF, 1'b0, 8'h12, 8'h00, 8'h00);
        op1(1'b1, 14'h01FF, 1'b0, 8'h00, 8'h12, 8'h77);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
